// File: rtl/dma_guard_check_scheduler.sv
// dma_guard_check_scheduler
// Shares one metadata BRAM port and one hash_engine between the AXI read- and
// write-address check requesters. One check is in flight at a time. Each check
// produces a pass/deny verdict, and every deny is counted and latched as an interrupt.
//
// Ports
//   data_clk, data_resetn        clock, async active-low reset
//   rd_/wr_req_valid/ready       check request handshake per channel
//   rd_/wr_req_addr, _len        tagged pointer ([63:48] PAC) and burst length
//   enb, addrb, doutb            metadata BRAM port B
//   hash_start/pointer/metadata  hash_engine request
//   hash_in, hash_done           hash_engine result
//   res_valid/ready/pass/channel/timeout  verdict handshake
//   busy, interrupt, irq_clear, deny_count  status
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | arbitrate between rd/wr requesters, accept one request
// BRAM      | enb held BRAM_LATENCY cycles, metadata captured on last
// CHECK     | bounds compares registered, hash_start pulsed
// HASH_WAIT | wait for hash_done or the timeout count
// RESULT    | verdict presented until res_ready
module dma_guard_check_scheduler #(
  parameter int BRAM_LATENCY = 2,
  parameter int HASH_TIMEOUT = 255
) (
  input  logic         data_clk,
  input  logic         data_resetn,
  input  logic         rd_req_valid,
  output logic         rd_req_ready,
  input  logic [63:0]  rd_req_addr,
  input  logic [7:0]   rd_req_len,
  input  logic         wr_req_valid,
  output logic         wr_req_ready,
  input  logic [63:0]  wr_req_addr,
  input  logic [7:0]   wr_req_len,
  output logic         enb,
  output logic [15:0]  addrb,
  input  logic [127:0] doutb,
  output logic         hash_start,
  output logic [63:0]  hash_pointer,
  output logic [127:0] hash_metadata,
  input  logic [15:0]  hash_in,
  input  logic         hash_done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_pass,
  output logic         res_channel,
  output logic         res_timeout,
  output logic         busy,
  output logic         interrupt,
  input  logic         irq_clear,
  output logic [15:0]  deny_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BRAM      = 3'd1,
    S_CHECK     = 3'd2,
    S_HASH_WAIT = 3'd3,
    S_RESULT    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic        arb_en;
  logic        last_grant;   // 1 = write
  logic        grant_rd, grant_wr, accept;
  logic [15:0] pac_q;
  logic [47:0] addr_q;
  logic [7:0]  len_q;
  logic        chan_q;
  logic [3:0]  bram_cnt;
  logic [7:0]  to_cnt;
  logic        to_hit;
  logic        lower_ok, upper_ok;
  logic        done_q;
  logic [15:0] hash_q;
  logic [48:0] last_sum;

  // Arbitration is held off for the first cycle after reset so a requester
  // holding valid through reset is never accepted on the release edge.
  always_comb begin
    grant_rd     = rd_req_valid && (!wr_req_valid || last_grant);
    grant_wr     = wr_req_valid && !grant_rd;
    rd_req_ready = (state == S_IDLE) && arb_en && grant_rd;
    wr_req_ready = (state == S_IDLE) && arb_en && grant_wr;
    accept       = rd_req_ready || wr_req_ready;
  end

  assign last_sum     = {1'b0, addr_q} + {41'd0, len_q};
  assign to_hit       = (to_cnt == 8'(HASH_TIMEOUT));
  assign hash_pointer = {16'h0, addr_q};
  assign enb          = (state == S_BRAM);
  assign hash_start   = (state == S_CHECK);
  assign res_valid    = (state == S_RESULT);
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (accept) state_nxt = S_BRAM;
      S_BRAM:      if (bram_cnt == 4'd0) state_nxt = S_CHECK;
      S_CHECK:     state_nxt = S_HASH_WAIT;
      S_HASH_WAIT: if (done_q || to_hit) state_nxt = S_RESULT;
      S_RESULT:    if (res_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      state  <= S_IDLE;
      arb_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      arb_en <= 1'b1;
    end
  end

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      pac_q         <= '0;
      addrb         <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      chan_q        <= 1'b0;
      bram_cnt      <= '0;
      hash_metadata <= '0;
      lower_ok      <= 1'b0;
      upper_ok      <= 1'b0;
      to_cnt        <= '0;
      done_q        <= 1'b0;
      hash_q        <= '0;
      res_pass      <= 1'b0;
      res_channel   <= 1'b0;
      res_timeout   <= 1'b0;
    end else begin
      // hash_done is registered for timing and only accepted while waiting,
      // so stray completions in other states are dropped here.
      done_q <= (state == S_HASH_WAIT) && hash_done;
      if ((state == S_HASH_WAIT) && hash_done) hash_q <= hash_in;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            pac_q    <= grant_wr ? wr_req_addr[63:48] : rd_req_addr[63:48];
            addrb    <= grant_wr ? wr_req_addr[63:48] : rd_req_addr[63:48];
            addr_q   <= grant_wr ? wr_req_addr[47:0]  : rd_req_addr[47:0];
            len_q    <= grant_wr ? wr_req_len         : rd_req_len;
            chan_q   <= grant_wr;
            bram_cnt <= 4'(BRAM_LATENCY - 1);
          end
        end
        S_BRAM: begin
          if (bram_cnt == 4'd0) hash_metadata <= doutb;
          else                  bram_cnt      <= bram_cnt - 4'd1;
        end
        S_CHECK: begin
          lower_ok <= hash_metadata[95:48] <= addr_q;
          // A carry out of the 48-bit address space can never be in bounds.
          upper_ok <= !last_sum[48] && (hash_metadata[47:0] >= last_sum[47:0]);
          to_cnt   <= '0;
        end
        S_HASH_WAIT: begin
          to_cnt <= to_cnt + 8'd1;
          if (done_q) begin
            res_pass    <= (hash_q == pac_q) && lower_ok && upper_ok;
            res_timeout <= 1'b0;
            res_channel <= chan_q;
          end else if (to_hit) begin
            res_pass    <= 1'b0;
            res_timeout <= 1'b1;
            res_channel <= chan_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge data_clk or negedge data_resetn) begin
    if (!data_resetn) begin
      last_grant <= 1'b1;
      interrupt  <= 1'b0;
      deny_count <= '0;
    end else begin
      if (res_valid && res_ready) last_grant <= chan_q;
      // A deny in the same cycle as irq_clear keeps the interrupt set.
      if (res_valid && res_ready && !res_pass) begin
        interrupt <= 1'b1;
        if (deny_count != 16'hFFFF) deny_count <= deny_count + 16'd1;
      end else if (irq_clear) begin
        interrupt <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dma_guard_check_scheduler.md
# dma_guard_check_scheduler

Sequences and shares the single DMA-guard authentication datapath (metadata BRAM port B plus one hash_engine instance) between the AXI read-address and write-address check requesters. Requests are arbitrated round-robin, one in flight at a time. Each request gets a pass/deny verdict from the PAC compare and the bounds checks. Denies raise a sticky interrupt and are counted. The block sits between the AXI address-channel gating logic and the shared metadata/hash resources.

## Interface
- BRAM_LATENCY, 2: cycles enb is held before doutb is sampled (1..15).
- HASH_TIMEOUT, 255: max cycles to wait for hash_done before forced deny (1..255).
- data_clk  in  1  sole clock, rising edge.
- data_resetn  in  1  asynchronous, active-low reset.
- rd_req_valid / wr_req_valid  in  1 each  check request from AR / AW path.
- rd_req_ready / wr_req_ready  out  1 each  request accepted this cycle.
- rd_req_addr / wr_req_addr  in  64 each  tagged pointer: [63:48] PAC, [47:0] address.
- rd_req_len / wr_req_len  in  8 each  AXI burst length field.
- enb  out  1  BRAM port-B enable.
- addrb  out  16  BRAM address (PAC of the granted request).
- doutb  in  128  metadata: [95:48] lower bound, [47:0] upper bound.
- hash_start  out  1  one-cycle start pulse to hash_engine.
- hash_pointer  out  64  {16'h0, address[47:0]} of the granted request.
- hash_metadata  out  128  captured metadata.
- hash_in  in  16  hash_engine result.
- hash_done  in  1  hash_engine completion.
- res_valid  out  1  verdict available.
- res_ready  in  1  verdict consumed.
- res_pass  out  1  1 = access authorised.
- res_channel  out  1  0 = read, 1 = write.
- res_timeout  out  1  deny was caused by hash timeout.
- busy  out  1  state != IDLE.
- interrupt  out  1  sticky deny flag.
- irq_clear  in  1  clears interrupt.
- deny_count  out  16  saturating count of denies.

## Operation
- States: IDLE, BRAM, CHECK, HASH_WAIT, RESULT.
- IDLE arbitration:
  - Only one valid: grant it.
  - Both valid: grant the channel not granted last. The last_grant register resets to write, so read wins the first tie.
  - Exactly one of rd_req_ready/wr_req_ready is high, combinationally, for the granted channel while in IDLE. Both are 0 in all other states.
- On handshake:
  - Latch PAC, address[47:0], len and channel.
  - addrb <= PAC; go to BRAM.
- BRAM: enb=1 for BRAM_LATENCY cycles. On the final cycle, capture doutb into hash_metadata, drop enb and go to CHECK.
- CHECK (1 cycle):
  - hash_start=1.
  - lower_ok = lower_bound <= address.
  - last = address + len, computed 49-bit. upper_ok = carry==0 && upper_bound >= last[47:0].
  - Go to HASH_WAIT and clear the timeout counter.
- HASH_WAIT:
  - On hash_done: pass = (hash_in == PAC) && lower_ok && upper_ok; go to RESULT.
  - Else if counter reaches HASH_TIMEOUT: pass=0, res_timeout=1; go to RESULT.
  - hash_done outside HASH_WAIT is ignored.
- RESULT:
  - res_valid=1; res_pass, res_channel and res_timeout are stable.
  - On res_ready, go to IDLE and update last_grant.
  - A deny sets interrupt and increments deny_count, saturating at 16'hFFFF, on the res_valid&&res_ready cycle.
- irq_clear clears interrupt. If irq_clear and a new deny occur in the same cycle, the deny wins and interrupt stays 1.
- Reset values: all outputs 0, state IDLE, last_grant = write.
- Reset mid-operation aborts the check with no result. The requester still holds valid and is re-arbitrated after reset.

## Timing
- The handshake edge is E0. With hash_done high in the first HASH_WAIT cycle, res_valid rises BRAM_LATENCY+3 cycles after E0 (5 with the default).
- The earliest next handshake is the cycle after the res_valid&&res_ready edge. There is no overlap of requests.
- hash_start is high for exactly one cycle per request.
- enb is high for exactly BRAM_LATENCY cycles per request, and addrb is stable throughout.
- Timeout deny: res_valid rises BRAM_LATENCY+3+HASH_TIMEOUT cycles after E0 (approximate, ±1; the exact counting convention is fixed at implementation).

## Test plan
- Single read pass: rd addr=0x1234_0000_0000_1000, len=0x10, metadata lower=0x800, upper=0x2000, hash_in=0x1234 with done one cycle after start -> res_valid at E0+5, res_pass=1, res_channel=0, interrupt=0.
- Bounds deny: same request, upper=0x100F (last=0x1010) -> res_pass=0, interrupt=1, deny_count=1; then upper=0x1010 -> pass.
- Round-robin: rd and wr held valid continuously with 4 checks completed -> grants alternate R, W, R, W; both ready never high together.
- Hash mismatch and timeout: hash_in=0x1235 -> deny. hash_done never asserted, HASH_TIMEOUT=8 -> deny with res_timeout=1.
- Backpressure and irq: res_ready held low for 10 cycles -> res_valid and fields stable, no new grant. irq_clear pulsed in the same cycle as a deny handshake -> interrupt stays 1.
- Reset mid-HASH_WAIT: data_resetn low for 1 cycle -> all outputs 0; the request is re-granted and completes normally afterwards.
